// File: rtl/bus_controller.sv
// CPU-to-slave bus controller: decodes ROM/RAM/IO windows and runs one transfer at a time.
// Optional ACCESS-state timeout abort is compiled in when BUS_TIMEOUT_EN is defined.
module bus_controller #(
  parameter logic [31:0] ROM_BASE       = 32'h0000_0000,
  parameter logic [31:0] RAM_BASE       = 32'h0001_0000,
  parameter logic [31:0] IO_BASE        = 32'h5000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_cpu_request,
  input  logic        i_cpu_rw,
  input  logic [31:0] i_cpu_address,
  input  logic [31:0] i_cpu_wdata,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_ready,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  output logic        o_bus_rw,
  output logic        o_rom_request,
  output logic        o_ram_request,
  output logic        o_io_request,
  input  logic        i_rom_ready,
  input  logic        i_ram_ready,
  input  logic        i_io_ready,
  input  logic [31:0] i_rom_rdata,
  input  logic [31:0] i_ram_rdata,
  input  logic [31:0] i_io_rdata,
  output logic        o_bus_error
);

  localparam logic [31:0] ROM_SIZE = 32'h0001_0000;
  localparam logic [31:0] RAM_SIZE = 32'h0002_0000;
  localparam logic [31:0] IO_SIZE  = 32'h1000_0000;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_ROM, SEL_RAM, SEL_IO} sel_t;

  state_t      state_q, state_d;
  sel_t        sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        sel_ready;
  logic [31:0] sel_rdata;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  // Subtracting before comparing keeps the upper bound free of base+size overflow.
  function automatic logic in_window(input logic [31:0] a, input logic [31:0] base,
                                     input logic [31:0] size);
    return (a >= base) && ((a - base) < size);
  endfunction

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    case (sel_q)
      SEL_ROM: begin sel_ready = i_rom_ready; sel_rdata = i_rom_rdata; end
      SEL_RAM: begin sel_ready = i_ram_ready; sel_rdata = i_ram_rdata; end
      SEL_IO:  begin sel_ready = i_io_ready;  sel_rdata = i_io_rdata;  end
      default: begin sel_ready = 1'b0;        sel_rdata = '0;          end
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_cpu_request) begin
          rw_d    = i_cpu_rw;
          wdata_d = i_cpu_wdata;
          rdata_d = '0;
`ifdef BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
          if (in_window(i_cpu_address, ROM_BASE, ROM_SIZE)) begin
            addr_d = i_cpu_address - ROM_BASE;
            if (i_cpu_rw) begin
              // ROM writes are dropped but still acknowledged.
              sel_d   = SEL_NONE;
              err_d   = 1'b1;
              state_d = S_RESPOND;
            end else begin
              sel_d   = SEL_ROM;
              state_d = S_ACCESS;
            end
          end else if (in_window(i_cpu_address, RAM_BASE, RAM_SIZE)) begin
            addr_d  = i_cpu_address - RAM_BASE;
            sel_d   = SEL_RAM;
            state_d = S_ACCESS;
          end else if (in_window(i_cpu_address, IO_BASE, IO_SIZE)) begin
            addr_d  = i_cpu_address - IO_BASE;
            sel_d   = SEL_IO;
            state_d = S_ACCESS;
          end else begin
            addr_d  = i_cpu_address;
            sel_d   = SEL_NONE;
            err_d   = 1'b1;
            state_d = S_RESPOND;
          end
        end
      end
      S_ACCESS: begin
        if (sel_ready) begin
          if (!rw_q) rdata_d = sel_rdata;
          state_d = S_RESPOND;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          rdata_d = 32'hDEAD_BEEF;
          err_d   = 1'b1;
          state_d = S_RESPOND;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_RESPOND: begin
        if (!i_cpu_request) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      sel_q   <= SEL_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Requests derive from registered state, so they fall on the same edge that leaves ACCESS.
  assign o_rom_request = (state_q == S_ACCESS) && (sel_q == SEL_ROM);
  assign o_ram_request = (state_q == S_ACCESS) && (sel_q == SEL_RAM);
  assign o_io_request  = (state_q == S_ACCESS) && (sel_q == SEL_IO);
  assign o_cpu_ready   = (state_q == S_RESPOND);
  assign o_cpu_rdata   = rdata_q;
  assign o_bus_address = addr_q;
  assign o_bus_wdata   = wdata_q;
  assign o_bus_rw      = rw_q;
  assign o_bus_error   = err_q;

endmodule

// File: tb/tb_bus_controller.sv
// Directed table-driven bench for bus_controller with per-slave ready/data models.
module tb_bus_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_rw;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata, bus_addr, bus_wdata;
  logic        cpu_ready, bus_rw, bus_err;
  logic        rom_req, ram_req, io_req;
  logic        rom_rdy, ram_rdy, io_rdy;
  logic [31:0] rom_rd, ram_rd, io_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_controller #(
    .ROM_BASE(32'h0000_0000),
    .RAM_BASE(32'h0001_0000),
    .IO_BASE(32'h5000_0000),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .i_clock(clk), .i_reset(rst),
    .i_cpu_request(cpu_req), .i_cpu_rw(cpu_rw),
    .i_cpu_address(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_ready(cpu_ready),
    .o_bus_address(bus_addr), .o_bus_wdata(bus_wdata), .o_bus_rw(bus_rw),
    .o_rom_request(rom_req), .o_ram_request(ram_req), .o_io_request(io_req),
    .i_rom_ready(rom_rdy), .i_ram_ready(ram_rdy), .i_io_ready(io_rdy),
    .i_rom_rdata(rom_rd), .i_ram_rdata(ram_rd), .i_io_rdata(io_rd),
    .o_bus_error(bus_err)
  );

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] srdata;
    int unsigned wait_n;
    logic [2:0]  sel;      // {io, ram, rom}
    logic [31:0] off;
    logic [31:0] exp_rdata;
    int unsigned exp_lat;
    int unsigned exp_reqc;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Non-selected slaves always claim ready with junk data; only the selected one waits.
  task automatic set_slaves(input vec_t v, input int unsigned seen);
    logic r;
    r = (seen >= v.wait_n + 1);
    rom_rdy = v.sel[0] ? r : 1'b1;
    ram_rdy = v.sel[1] ? r : 1'b1;
    io_rdy  = v.sel[2] ? r : 1'b1;
    rom_rd  = v.sel[0] ? v.srdata : 32'hBAD0_0001;
    ram_rd  = v.sel[1] ? v.srdata : 32'hBAD0_0002;
    io_rd   = v.sel[2] ? v.srdata : 32'hBAD0_0003;
  endtask

  task automatic run(input vec_t v, input int idx);
    int unsigned lat, seen, badreq, badbus;
    logic done;
    logic [2:0] reqv;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    cpu_req = 1'b1; cpu_rw = v.rw; cpu_addr = v.addr; cpu_wdata = v.wdata;
    set_slaves(v, 0);
    lat = 0; seen = 0; badreq = 0; badbus = 0; done = 1'b0;
    while (!done && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      reqv = {io_req, ram_req, rom_req};
      if (cpu_ready) begin
        done = 1'b1;
        chk({tag, "_req_at_ready"}, 32'(reqv), 32'h0);
      end else begin
        if (reqv != 3'b000) begin
          if (reqv != v.sel) badreq++;
          else seen++;
          if (bus_addr !== v.off || bus_rw !== v.rw || (v.rw && bus_wdata !== v.wdata)) badbus++;
        end
        // CPU inputs wander while held; latched copies must not follow.
        cpu_addr = ~v.addr; cpu_wdata = ~v.wdata; cpu_rw = ~v.rw;
        set_slaves(v, seen);
      end
    end
    chk({tag, "_latency"}, lat, v.exp_lat);
    chk({tag, "_req_cycles"}, seen, v.exp_reqc);
    chk({tag, "_wrong_req"}, badreq, 0);
    chk({tag, "_bus_fields"}, badbus, 0);
    chk({tag, "_rdata"}, cpu_rdata, v.exp_rdata);
    chk({tag, "_error"}, 32'(bus_err), 32'(v.exp_err));
    @(posedge clk); #1;
    chk({tag, "_ready_held"}, 32'(cpu_ready), 32'h1);
    chk({tag, "_no_reissue"}, 32'({io_req, ram_req, rom_req}), 32'h0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ready_drop"}, 32'(cpu_ready), 32'h0);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{1'b0, 32'h0001_0010, 32'h0, 32'h1234_5678, 0, 3'b010, 32'h10, 32'h1234_5678, 2, 1, 1'b0};
    vecs[1]  = '{1'b1, 32'h5000_0004, 32'hA5A5_A5A5, 32'h7777_7777, 3, 3'b100, 32'h4, 32'h0, 5, 4, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_FFFC, 32'h0, 32'hCAFE_F00D, 1, 3'b001, 32'hFFFC, 32'hCAFE_F00D, 3, 2, 1'b0};
    vecs[3]  = '{1'b0, 32'h0002_FFFC, 32'h0, 32'h0BAD_F00D, 2, 3'b010, 32'h0001_FFFC, 32'h0BAD_F00D, 4, 3, 1'b0};
    vecs[4]  = '{1'b1, 32'h0001_0000, 32'h1122_3344, 32'h0, 0, 3'b010, 32'h0, 32'h0, 2, 1, 1'b0};
    vecs[5]  = '{1'b0, 32'h5FFF_FFFC, 32'h0, 32'h55AA_55AA, 0, 3'b100, 32'h0FFF_FFFC, 32'h55AA_55AA, 2, 1, 1'b0};
    vecs[6]  = '{1'b0, 32'h4000_0000, 32'h0, 32'h0, 0, 3'b000, 32'h0, 32'h0, 1, 0, 1'b1};
    vecs[7]  = '{1'b0, 32'h0003_0000, 32'h0, 32'h0, 0, 3'b000, 32'h0, 32'h0, 1, 0, 1'b1};
    vecs[8]  = '{1'b0, 32'h6000_0000, 32'h0, 32'h0, 0, 3'b000, 32'h0, 32'h0, 1, 0, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0200, 32'h0, 32'h8765_4321, 0, 3'b001, 32'h200, 32'h8765_4321, 2, 1, 1'b1};
    vecs[10] = '{1'b1, 32'h0000_0100, 32'hDEAD_C0DE, 32'h0, 0, 3'b000, 32'h0, 32'h0, 1, 0, 1'b1};

    rst = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    rom_rdy = 1'b0; ram_rdy = 1'b0; io_rdy = 1'b0; rom_rd = '0; ram_rd = '0; io_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(cpu_ready), 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_bus_rw", 32'(bus_rw), 32'h0);
    chk("rst_reqs", 32'({io_req, ram_req, rom_req}), 32'h0);
    chk("rst_error", 32'(bus_err), 32'h0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 11; i++) run(vecs[i], i);

    // Reset in the middle of a RAM access aborts it on the next edge.
    @(negedge clk);
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h0001_0020;
    rom_rdy = 1'b0; ram_rdy = 1'b0; io_rdy = 1'b0;
    @(posedge clk); #1;
    chk("mid_ram_req", 32'(ram_req), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_ram_req", 32'(ram_req), 32'h0);
    chk("abort_ready", 32'(cpu_ready), 32'h0);
    chk("abort_error", 32'(bus_err), 32'h0);
    rst = 1'b0; cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle_ready", 32'(cpu_ready), 32'h0);

    v = '{1'b0, 32'h0000_0200, 32'h0, 32'h1357_2468, 0, 3'b001, 32'h200, 32'h1357_2468, 2, 1, 1'b0};
    run(v, 11);

`ifdef BUS_TIMEOUT_EN
    v = '{1'b0, 32'h0000_0400, 32'h0, 32'h0, 32'h0000_FFFF, 3'b001, 32'h400, 32'hDEAD_BEEF, 256, 255, 1'b1};
    run(v, 12);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
